// File: rtl/mavg_pkg.sv
// Shared types and helpers for the moving-average FIR sequencer.
package mavg_pkg;

    // Default widths used by the sequencer and its surroundings.
    localparam int DEF_IN_DATA_WIDTH  = 16;
    localparam int DEF_OUT_DATA_WIDTH = 32;

    // Sequencer states: flush the filter, wait for a sample, wait for the
    // filter result, hold the result until downstream takes it.
    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // A factor of 0 is meaningless for an average, so it becomes 1; anything
    // beyond the filter's window depth is pinned to that depth.
    function automatic int unsigned clamp_factor(input int unsigned factor,
                                                 input int unsigned max_factor);
        if (factor == 0) begin
            return 1;
        end else if (factor > max_factor) begin
            return max_factor;
        end else begin
            return factor;
        end
    endfunction

endpackage

// File: rtl/mavg_timeout_counter.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Loading N-1 therefore yields expire on the N-th cycle after the load.
module mavg_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;

    // Load has priority; otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/mavg_fir_sequencer.sv
// Sequences a single moving-average FIR: one sample in flight, result held
// on a ready/valid output, factor changes applied by flushing the filter,
// and a timeout that recovers from a lost filter response.
module mavg_fir_sequencer
    import mavg_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int DEFAULT_FACTOR = 5,
    parameter int MAX_FACTOR     = 64,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_DATA_WIDTH-1:0]  cfg_factor,
    input  logic                      cfg_update,
    output logic                      cfg_busy,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_DATA_WIDTH-1:0]  s_data,
    output logic                      fir_rst,
    output logic [IN_DATA_WIDTH-1:0]  fir_mavg_factor,
    output logic                      fir_in_valid,
    output logic [IN_DATA_WIDTH-1:0]  fir_in_data,
    input  logic                      fir_out_valid,
    input  logic [OUT_DATA_WIDTH-1:0] fir_out_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_DATA_WIDTH-1:0] m_data,
    output logic                      m_settled,
    output logic                      err_timeout
);

    localparam int MAX_CYCLES = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IN_DATA_WIDTH-1:0] DEFAULT_FACTOR_W = IN_DATA_WIDTH'(DEFAULT_FACTOR);

    state_t                     state_reg;
    state_t                     state_next;
    logic                       pending_reg;
    logic                       pending_next;
    logic [IN_DATA_WIDTH-1:0]   pending_factor_reg;
    logic [IN_DATA_WIDTH-1:0]   factor_reg;
    logic [IN_DATA_WIDTH-1:0]   settle_reg;
    logic [IN_DATA_WIDTH-1:0]   settle_inc;
    logic [IN_DATA_WIDTH-1:0]   clamped_factor;

    logic latch_factor;   // IDLE -> FLUSH with a pending factor
    logic accept;         // input handshake
    logic capture;        // filter result taken in WAIT
    logic timeout;        // filter result never arrived
    logic cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic cnt_expire;

    assign clamped_factor = IN_DATA_WIDTH'(clamp_factor(32'(cfg_factor), MAX_FACTOR));
    assign settle_inc     = settle_reg + 1'b1;

    // Next-state and event decode for the sequencer.
    always_comb begin
        state_next   = state_reg;
        latch_factor = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        timeout      = 1'b0;
        case (state_reg)
            ST_FLUSH: begin
                if (cnt_expire) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (pending_reg) begin
                    latch_factor = 1'b1;
                    state_next   = ST_FLUSH;
                end else if (s_valid && s_ready) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fir_out_valid) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end else if (cnt_expire) begin
                    timeout    = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (m_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_FLUSH;
        endcase

        // A strobe in the same cycle as the latch stays pending.
        if (cfg_update) begin
            pending_next = 1'b1;
        end else if (latch_factor) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending_reg;
        end
    end

    // One counter times both the flush hold and the response timeout.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = FLUSH_LOAD;
        if (rst || latch_factor || timeout) begin
            cnt_load  = 1'b1;
            cnt_value = FLUSH_LOAD;
        end else if (accept) begin
            cnt_load  = 1'b1;
            cnt_value = TIMEOUT_LOAD;
        end
    end

    mavg_timeout_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clk        (clk),
        .load       (cnt_load),
        .load_value (cnt_value),
        .expire     (cnt_expire)
    );

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_FLUSH;
            pending_reg        <= 1'b0;
            pending_factor_reg <= DEFAULT_FACTOR_W;
            factor_reg         <= DEFAULT_FACTOR_W;
            settle_reg         <= '0;
            s_ready            <= 1'b0;
            fir_in_valid       <= 1'b0;
            fir_in_data        <= '0;
            m_valid            <= 1'b0;
            m_data             <= '0;
            m_settled          <= 1'b0;
            err_timeout        <= 1'b0;
            cfg_busy           <= 1'b1;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            fir_in_valid <= accept;
            s_ready      <= (state_next == ST_IDLE) && !pending_next;
            cfg_busy     <= pending_next || (state_next == ST_FLUSH);

            if (cfg_update) pending_factor_reg <= clamped_factor;

            if (latch_factor) factor_reg <= pending_factor_reg;

            if (latch_factor || timeout) begin
                settle_reg <= '0;
            end else if (capture) begin
                settle_reg <= (settle_inc > factor_reg) ? factor_reg : settle_inc;
            end

            if (accept) fir_in_data <= s_data;

            if (capture) begin
                m_data    <= fir_out_data;
                m_valid   <= 1'b1;
                m_settled <= (settle_inc >= factor_reg);
            end else if (state_reg == ST_HOLD && m_ready) begin
                m_valid <= 1'b0;
            end

            if (timeout) err_timeout <= 1'b1;
        end
    end

    assign fir_mavg_factor = factor_reg;
    assign fir_rst         = rst || (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_mavg_fir_sequencer.sv
// Directed bench for mavg_fir_sequencer with a behavioural sum-of-window
// FIR model (latency 3) that can be told to drop a response.
module tb_mavg_fir_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_factor = '0;
    logic        cfg_update = 1'b0;
    logic        cfg_busy;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        fir_rst;
    logic [15:0] fir_mavg_factor;
    logic        fir_in_valid;
    logic [15:0] fir_in_data;
    logic        fir_out_valid;
    logic [31:0] fir_out_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_settled;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    logic drop_enable = 1'b0;

    always #5 clk = ~clk;

    mavg_fir_sequencer #(
        .IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(32), .DEFAULT_FACTOR(5),
        .MAX_FACTOR(64), .FLUSH_CYCLES(4), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .cfg_factor(cfg_factor), .cfg_update(cfg_update),
        .cfg_busy(cfg_busy), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_rst(fir_rst), .fir_mavg_factor(fir_mavg_factor), .fir_in_valid(fir_in_valid),
        .fir_in_data(fir_in_data), .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_settled(m_settled),
        .err_timeout(err_timeout)
    );

    // Behavioural FIR: output = sum of the last 'factor' samples since reset.
    logic [31:0] hist [0:63];
    logic [2:0]  pv;
    logic [31:0] pd [0:2];

    function automatic logic [31:0] model_sum(input logic [15:0] d, input logic [15:0] f);
        logic [31:0] s;
        int lim;
        s = {16'd0, d};
        lim = (f > 16'd64) ? 64 : int'(f);
        for (int k = 0; k < lim - 1; k++) s += hist[k];
        return s;
    endfunction

    always @(posedge clk) begin
        if (fir_rst) begin
            for (int k = 0; k < 64; k++) hist[k] <= '0;
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], fir_in_valid & ~drop_enable};
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            if (fir_in_valid) begin
                pd[0]   <= model_sum(fir_in_data, fir_mavg_factor);
                hist[0] <= {16'd0, fir_in_data};
                for (int k = 1; k < 64; k++) hist[k] <= hist[k-1];
            end
        end
    end

    assign fir_out_valid = pv[2];
    assign fir_out_data  = pd[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a sample and wait (bounded) for the handshake edge.
    task automatic send_sample(input logic [15:0] d, output logic ok);
        int n;
        ok = 1'b1;
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (!s_ready && n < 200) begin tick(); n++; end
        if (!s_ready) ok = 1'b0;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output logic ok);
        int n;
        n = 0;
        while (!m_valid && n < 100) begin tick(); n++; end
        ok = m_valid;
    endtask

    // Wait for fir_rst to rise (bounded) and count how long it stays high.
    task automatic count_fir_rst(output int hi);
        int n;
        n = 0;
        while (!fir_rst && n < 20) begin tick(); n++; end
        hi = 0;
        while (fir_rst && hi < 50) begin hi++; tick(); end
    endtask

    task automatic test_reset();
        int hi;
        rst = 1'b1;
        tick(); tick();
        checks++; if (fir_rst !== 1'b1) begin errors++; $display("FAIL reset_fir_rst: got %b want 1", fir_rst); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_cfg_busy: got %b want 1", cfg_busy); end
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || fir_in_valid !== 1'b0 || err_timeout !== 1'b0)
            begin errors++; $display("FAIL reset_flags: got s_ready=%b m_valid=%b fir_in_valid=%b err=%b want 0000", s_ready, m_valid, fir_in_valid, err_timeout); end
        checks++; if (fir_mavg_factor !== 16'd5) begin errors++; $display("FAIL reset_factor: got %0d want 5", fir_mavg_factor); end
        checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
        rst = 1'b0;
        #1;
        count_fir_rst(hi);
        checks++; if (hi != 4) begin errors++; $display("FAIL reset_flush_len: got %0d want 4", hi); end
        checks++; if (cfg_busy !== 1'b0 || s_ready !== 1'b1)
            begin errors++; $display("FAIL reset_idle: got cfg_busy=%b s_ready=%b want 0 1", cfg_busy, s_ready); end
        $display("reset: flush length %0d", hi);
    endtask

    task automatic test_stream();
        logic ok1, ok2;
        logic [31:0] exp_sum [0:9] = '{0, 1, 3, 6, 10, 15, 20, 25, 30, 35};
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_sample(16'(i), ok1);
            wait_mvalid(ok2);
            checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL stream_timeout[%0d]: got handshake=%b result=%b want 1 1", i, ok1, ok2); end
            checks++; if (m_data !== exp_sum[i]) begin errors++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, m_data, exp_sum[i]); end
            checks++; if (m_settled !== (i >= 4)) begin errors++; $display("FAIL stream_settled[%0d]: got %b want %b", i, m_settled, (i >= 4)); end
            $display("stream: sample %0d -> m_data %0d settled %b", i, m_data, m_settled);
            tick();
        end
    endtask

    task automatic test_cfg_clamp();
        int hi;
        logic ok1, ok2;
        logic [15:0] req [0:1] = '{16'd0, 16'd100};
        logic [15:0] want [0:1] = '{16'd1, 16'd64};
        for (int j = 0; j < 2; j++) begin
            cfg_factor = req[j];
            cfg_update = 1'b1;
            tick();
            cfg_update = 1'b0;
            checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL cfg_busy_rise[%0d]: got %b want 1", j, cfg_busy); end
            count_fir_rst(hi);
            checks++; if (hi != 4) begin errors++; $display("FAIL cfg_flush_len[%0d]: got %0d want 4", j, hi); end
            checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_fall[%0d]: got %b want 0", j, cfg_busy); end
            checks++; if (fir_mavg_factor !== want[j]) begin errors++; $display("FAIL cfg_factor[%0d]: got %0d want %0d", j, fir_mavg_factor, want[j]); end
            $display("cfg: request %0d -> factor %0d flush %0d", req[j], fir_mavg_factor, hi);
            if (j == 0) begin
                send_sample(16'd7, ok1);
                wait_mvalid(ok2);
                checks++; if (!(ok1 && ok2) || m_data !== 32'd7 || m_settled !== 1'b1)
                    begin errors++; $display("FAIL cfg_factor1_result: got data=%0d settled=%b want 7 1", m_data, m_settled); end
                tick();
            end
        end
    endtask

    task automatic test_cfg_during_wait();
        int hi;
        logic ok1, ok2;
        logic [31:0] exp_sum [0:2] = '{1, 3, 6};
        send_sample(16'd10, ok1);
        cfg_factor = 16'd3;
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL wait_cfg_busy: got %b want 1", cfg_busy); end
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd10 || m_settled !== 1'b0)
            begin errors++; $display("FAIL wait_old_result: got data=%0d settled=%b want 10 0", m_data, m_settled); end
        checks++; if (fir_mavg_factor !== 16'd64) begin errors++; $display("FAIL wait_old_factor: got %0d want 64", fir_mavg_factor); end
        tick();
        count_fir_rst(hi);
        checks++; if (hi != 4 || fir_mavg_factor !== 16'd3)
            begin errors++; $display("FAIL wait_flush: got len=%0d factor=%0d want 4 3", hi, fir_mavg_factor); end
        for (int i = 0; i < 3; i++) begin
            send_sample(16'(i + 1), ok1);
            wait_mvalid(ok2);
            checks++; if (!(ok1 && ok2) || m_data !== exp_sum[i] || m_settled !== (i == 2))
                begin errors++; $display("FAIL wait_new[%0d]: got data=%0d settled=%b want %0d %b", i, m_data, m_settled, exp_sum[i], (i == 2)); end
            $display("cfg-in-wait: sample %0d -> m_data %0d settled %b", i + 1, m_data, m_settled);
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic ok1, ok2, stable, no_ready, no_issue;
        m_ready = 1'b0;
        send_sample(16'd20, ok1);
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd25)
            begin errors++; $display("FAIL bp_first: got data=%0d want 25", m_data); end
        s_valid = 1'b1;
        s_data  = 16'd21;
        stable = 1'b1; no_ready = 1'b1; no_issue = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_data !== 32'd25 || m_valid !== 1'b1) stable = 1'b0;
            if (s_ready !== 1'b0) no_ready = 1'b0;
            if (fir_in_valid !== 1'b0) no_issue = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", stable); end
        checks++; if (no_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready: got %b want 1", no_ready); end
        checks++; if (no_issue !== 1'b1) begin errors++; $display("FAIL bp_no_issue: got %b want 1", no_issue); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_one_handshake: got m_valid=%b want 0", m_valid); end
        send_sample(16'd21, ok1);
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd44 || m_settled !== 1'b1)
            begin errors++; $display("FAIL bp_next: got data=%0d settled=%b want 44 1", m_data, m_settled); end
        $display("backpressure: held 25, next result %0d", m_data);
        tick();
    endtask

    task automatic test_timeout();
        int n, hi;
        logic ok1, ok2, seen;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got %b want 0", err_timeout); end
        drop_enable = 1'b1;
        send_sample(16'd30, ok1);
        checks++; if (!ok1 || fir_in_valid !== 1'b1) begin errors++; $display("FAIL to_issue: got fir_in_valid=%b want 1", fir_in_valid); end
        n = 0;
        seen = 1'b0;
        while (!err_timeout && n < 50) begin
            tick();
            n++;
            drop_enable = 1'b0;
            if (m_valid) seen = 1'b1;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL to_latency: got %0d want 10", n); end
        checks++; if (fir_rst !== 1'b1) begin errors++; $display("FAIL to_flush: got %b want 1", fir_rst); end
        count_fir_rst(hi);
        if (m_valid) seen = 1'b1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_no_output: got m_valid seen=%b want 0", seen); end
        send_sample(16'd5, ok1);
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd5 || m_settled !== 1'b0)
            begin errors++; $display("FAIL to_recover: got data=%0d settled=%b want 5 0", m_data, m_settled); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        $display("timeout: after %0d cycles, recovered m_data %0d", n, m_data);
        tick();
    endtask

    task automatic test_rst_in_hold();
        int hi;
        logic ok1, ok2;
        m_ready = 1'b0;
        send_sample(16'd8, ok1);
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd13) begin errors++; $display("FAIL rh_hold: got data=%0d want 13", m_data); end
        rst = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rh_m_valid: got %b want 0", m_valid); end
        checks++; if (fir_mavg_factor !== 16'd5) begin errors++; $display("FAIL rh_factor: got %0d want 5", fir_mavg_factor); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rh_err_clear: got %b want 0", err_timeout); end
        rst = 1'b0;
        #1;
        count_fir_rst(hi);
        checks++; if (hi != 4) begin errors++; $display("FAIL rh_flush_len: got %0d want 4", hi); end
        m_ready = 1'b1;
        send_sample(16'd2, ok1);
        wait_mvalid(ok2);
        checks++; if (!(ok1 && ok2) || m_data !== 32'd2 || m_settled !== 1'b0)
            begin errors++; $display("FAIL rh_after: got data=%0d settled=%b want 2 0", m_data, m_settled); end
        $display("rst-in-hold: flush %0d, next result %0d", hi, m_data);
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_cfg_clamp();
        test_cfg_during_wait();
        test_backpressure();
        test_timeout();
        test_rst_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
